// File: rtl/tcl_router_param.sv
// Parametrised VC router: input FIFOs -> round-robin arbiter -> output FIFOs, plus control FSM and stats counters.
// One word moved per cycle (push-to-transfer 1 cycle, pop data registered); a word stalls while its output FIFO count >= th_hi.

// Generic synchronous FIFO; push when full and pop when empty are ignored.
module tcl_router_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 8,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW-1:0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_wr = push && (count != AW'(DEPTH));
   assign do_rd = pop && (count != '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
         if (do_wr && !do_rd)      count <= count + AW'(1);
         else if (do_rd && !do_wr) count <= count - AW'(1);
      end
   end
endmodule

module tcl_router_param #(
   parameter int  CHANNELS = 4,
   parameter int  DATA_W   = 12,
   parameter int  DEPTH    = 8,
   parameter int  CNT_W    = 5,
   localparam int CW       = $clog2(CHANNELS),
   localparam int AW       = $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         init,
   input  logic [AW-1:0]                umbral_bajo,
   input  logic [AW-1:0]                umbral_alto,
   input  logic [CHANNELS-1:0]          push_in,
   input  logic [CHANNELS*DATA_W-1:0]   data_in,
   output logic [CHANNELS-1:0]          almost_full_in,
   input  logic [CHANNELS-1:0]          pop_out,
   output logic [CHANNELS*DATA_W-1:0]   data_out,
   output logic [CHANNELS-1:0]          valid_out,
   output logic [CHANNELS-1:0]          almost_empty_out,
   input  logic                         req,
   input  logic [CW:0]                  idx,
   output logic [CNT_W-1:0]             counter_out,
   output logic                         counter_valid,
   output logic [2:0]                   state,
   output logic                         error
);
   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);
   localparam logic [CW:0]   LAST_IDX = (CW+1)'(CHANNELS);

   state_t              state_q;
   state_t              state_d;
   logic [AW-1:0]       th_hi;
   logic [AW-1:0]       th_lo;
   logic [CW-1:0]       rr_ptr;
   logic [CNT_W-1:0]    stat_cnt [CHANNELS+1];

   logic [DATA_W-1:0]   in_head  [CHANNELS];
   logic [DATA_W-1:0]   out_head [CHANNELS];
   logic [AW-1:0]       in_cnt   [CHANNELS];
   logic [AW-1:0]       out_cnt  [CHANNELS];
   logic [CHANNELS-1:0] in_push;
   logic [CHANNELS-1:0] in_pop;
   logic [CHANNELS-1:0] in_full;
   logic [CHANNELS-1:0] out_push;
   logic [CHANNELS-1:0] out_pop_ok;
   logic [CHANNELS-1:0] out_empty;
   logic [CHANNELS-1:0] busy_vec;

   logic                run;
   logic                accept;
   logic                overflow;
   logic                underflow;
   logic                xfer;
   logic [CW-1:0]       win;
   logic [CW-1:0]       win_dest;
   logic [CW-1:0]       cand;
   logic [CW-1:0]       cand_dest;

   assign run       = (state_q == S_IDLE) || (state_q == S_ACTIVE);
   assign accept    = run || (state_q == S_INIT);
   assign overflow  = |(in_push & in_full);
   assign underflow = run && |(pop_out & out_empty);
   assign win_dest  = in_head[win][DATA_W-1 -: CW];
   assign state     = state_q;
   assign error     = (state_q == S_ERROR);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign in_full[i]          = (in_cnt[i] == FULL_CNT);
      assign out_empty[i]        = (out_cnt[i] == '0);
      assign busy_vec[i]         = (in_cnt[i] != '0) || !out_empty[i];
      assign in_push[i]          = accept && push_in[i];
      assign in_pop[i]           = xfer && (win == CW'(i));
      assign out_push[i]         = xfer && (win_dest == CW'(i));
      assign out_pop_ok[i]       = run && pop_out[i] && !out_empty[i];
      assign almost_full_in[i]   = (in_cnt[i] >= th_hi);
      assign almost_empty_out[i] = (out_cnt[i] <= th_lo);

      tcl_router_fifo #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_in_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (in_push[i]),
         .pop   (in_pop[i]),
         .din   (data_in[i*DATA_W +: DATA_W]),
         .dout  (in_head[i]),
         .count (in_cnt[i])
      );

      tcl_router_fifo #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_out_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (out_push[i]),
         .pop   (out_pop_ok[i]),
         .din   (in_head[win]),
         .dout  (out_head[i]),
         .count (out_cnt[i])
      );
   end

   // Round-robin search from rr_ptr; the FULL_CNT guard covers th_hi programmed above DEPTH.
   always_comb begin
      xfer      = 1'b0;
      win       = rr_ptr;
      cand      = '0;
      cand_dest = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         cand      = rr_ptr + CW'(k);
         cand_dest = in_head[cand][DATA_W-1 -: CW];
         if (!xfer && run && (in_cnt[cand] != '0) &&
             (out_cnt[cand_dest] < th_hi) && (out_cnt[cand_dest] != FULL_CNT)) begin
            xfer = 1'b1;
            win  = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_INIT;
         S_INIT: begin
            if (overflow)   state_d = S_ERROR;
            else if (!init) state_d = S_IDLE;
         end
         S_IDLE, S_ACTIVE: begin
            if (overflow || underflow) state_d = S_ERROR;
            else if (init)             state_d = S_INIT;
            else if (|busy_vec)        state_d = S_ACTIVE;
            else                       state_d = S_IDLE;
         end
         default: state_d = S_ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RESET;
         th_hi         <= AW'(DEPTH-1);
         th_lo         <= AW'(1);
         rr_ptr        <= '0;
         data_out      <= '0;
         valid_out     <= '0;
         counter_out   <= '0;
         counter_valid <= 1'b0;
         for (int k = 0; k < CHANNELS+1; k++) stat_cnt[k] <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_INIT) && init) begin
            th_hi <= umbral_alto;
            th_lo <= umbral_bajo;
         end
         if (xfer) begin
            rr_ptr             <= win + CW'(1);
            stat_cnt[CHANNELS] <= stat_cnt[CHANNELS] + CNT_W'(1);
         end
         valid_out <= out_pop_ok;
         for (int k = 0; k < CHANNELS; k++) begin
            if (out_pop_ok[k]) begin
               data_out[k*DATA_W +: DATA_W] <= out_head[k];
               stat_cnt[k]                  <= stat_cnt[k] + CNT_W'(1);
            end
         end
         if (req && (run || (state_q == S_ERROR)) && (idx <= LAST_IDX)) begin
            counter_out   <= stat_cnt[idx];
            counter_valid <= 1'b1;
         end else begin
            counter_out   <= '0;
            counter_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/tcl_router_param.md
Name: tcl_router_param

Overview:
Parametrised successor to the fixed 4-port transaction-layer core. It has CHANNELS input virtual-channel FIFOs and CHANNELS output FIFOs. A round-robin arbiter moves one word per cycle from an input FIFO to the output FIFO selected by the word's destination field, subject to almost-full backpressure. The block also contains the control FSM (thresholds, init, error) and a request/index-addressed bank of statistics counters. It sits between the link-side ingress and the per-port egress logic.

Parameters:
CHANNELS, 4, number of input and output channels (power of two, 2..16)
DATA_W, 12, word width in bits
DEPTH, 8, entries per FIFO (power of two, 4..64)
CNT_W, 5, statistics counter width
Derived: CW=clog2(CHANNELS), AW=clog2(DEPTH)+1

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
init  in  1  threshold-load request
umbral_bajo  in  AW  almost-empty threshold
umbral_alto  in  AW  almost-full threshold
push_in  in  CHANNELS  per-input-FIFO push
data_in  in  CHANNELS*DATA_W  input words; channel i occupies [i*DATA_W +: DATA_W]
almost_full_in  out  CHANNELS  input FIFO count >= th_hi
pop_out  in  CHANNELS  per-output-FIFO pop
data_out  out  CHANNELS*DATA_W  registered output words
valid_out  out  CHANNELS  data_out[i] updated this cycle
almost_empty_out  out  CHANNELS  output FIFO count <= th_lo
req  in  1  counter read request
idx  in  CW+1  counter index
counter_out  out  CNT_W  counter read data
counter_valid  out  1  counter_out valid
state  out  3  FSM state encoding
error  out  1  sticky error flag

Behaviour:
- Destination of a word = word[DATA_W-1 -: CW].
- Reset (synchronous, on a clock edge with reset=1):
  - All FIFOs emptied; data_out, valid_out, counter_out, counter_valid, error all 0.
  - th_hi=DEPTH-1, th_lo=1; round-robin pointer=0; all counters 0; state=RESET.
  - Reset asserted mid-operation discards all contents on that edge.
- FSM encodings: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
  - RESET -> INIT on the first cycle after reset deasserts.
  - INIT: each cycle with init=1, latch th_hi<=umbral_alto and th_lo<=umbral_bajo. Leave for IDLE when init=0.
  - IDLE -> ACTIVE when any FIFO is non-empty. ACTIVE -> IDLE when all 2*CHANNELS FIFOs are empty.
  - init=1 in IDLE or ACTIVE -> INIT. FIFO contents are kept.
  - Any overflow or underflow -> ERROR. ERROR is left only by reset.
- Pushes are accepted in INIT, IDLE and ACTIVE. Arbitration and pops run only in IDLE and ACTIVE.
- Overflow = push_in[i] while input count==DEPTH. Full is judged on the pre-cycle count even if the same FIFO is popped that cycle. The word is dropped.
- Underflow = pop_out[i] while output count==0. data_out[i] holds its value and valid_out[i]=0.
- Arbiter:
  - Eligible input j: non-empty, and the output FIFO named by its head word has count < th_hi.
  - Search starts at the pointer and wraps modulo CHANNELS. The first eligible j wins.
  - The winner's input pop and the output push happen in the same cycle. At most one transfer per cycle.
  - After a transfer the pointer becomes winner+1 mod CHANNELS; with no winner it is unchanged.
- Latency:
  - Push at edge t: word is visible for arbitration at t+1 and transferred at edge t+1.
  - Output pop allowed from t+2. data_out/valid_out are registered, so the word appears at t+3.
- Simultaneous push and pop on an output FIFO that is neither full nor empty: count is unchanged.
- Counters:
  - Counter k<CHANNELS increments on each successful pop_out[k].
  - Counter CHANNELS counts arbiter transfers.
  - All counters wrap at 2^CNT_W and count only in IDLE/ACTIVE.
- Counter read:
  - req=1 in IDLE, ACTIVE or ERROR -> next cycle counter_out=counter[idx], counter_valid=1 for one cycle.
  - idx>CHANNELS or a read in RESET/INIT -> counter_valid=0 and counter_out=0.
- error=1 iff state==ERROR. In ERROR, pushes, pops and arbitration are ignored; counters stay readable.

Test Plan:
1. Reset, init=1 with umbral_alto=6 and umbral_bajo=2, then init=0 -> state 0->1->2; almost_empty_out all 1.
2. Push 0x805 (dest 2) into input 0 at cycle t, pop_out[2] at t+2 -> data_out[2]=0x805 and valid_out[2]=1 at t+3; counter 2 reads 1.
3. Inputs 0..3 each hold 3 words with dest 1, pop_out[1] held high -> transfers in input order 0,1,2,3,0,1,2,3,0,1,2,3; counter 4 reads 12.
4. With th_hi=6, fill output 3 to 6 entries, pop_out[3] held at 0 -> input words for dest 3 stall. Words for other destinations still transfer, and almost_full_in rises at input count 6.
5. Nine pushes into input 1 with arbitration blocked -> 9th push sets error=1 and state=4; later pushes and pops have no effect; req with idx=4 still returns valid data.
6. 33 pops from a refilled output 0 with CNT_W=5 -> counter 0 reads 1 (wrap). Reset mid-stream -> all counts 0, outputs 0, state 0.
